// File: rtl/bec_la_host_if.sv
// Logic-analyzer bus between the BEC host sequencer and the controller.
// la_drv feeds the controller's la_data_in; la_mon carries its la_data_out back.
interface bec_la_host_if;
    logic [127:0] la_drv;
    logic [127:0] la_mon;

    modport master (output la_drv, input la_mon);
    modport slave  (input la_drv, output la_mon);
endinterface

// File: rtl/bec_la_host.sv
// Host-side sequencer for the BEC LA operand/result protocol: arms write mode, pushes 14
// operand half-words, starts the core, polls for completion, reads wout/zout, releases.
module bec_la_host #(
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned PROC_TIMEOUT = 2**20,
    parameter int unsigned ARM_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [162:0]       w1,
    input  logic [162:0]       z1,
    input  logic [162:0]       w2,
    input  logic [162:0]       z2,
    input  logic [162:0]       inv_w0,
    input  logic [162:0]       d,
    input  logic [162:0]       key,
    bec_la_host_if.master      la,
    output logic [162:0]       wout,
    output logic [162:0]       zout,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int unsigned OP_W      = 163;
    localparam int unsigned LO_W      = 82;
    localparam int unsigned NUM_OPS   = 7;
    localparam int unsigned NUM_WORDS = 14;
    localparam int unsigned SEL_W     = 14;
    localparam int unsigned TMO_A     = (ACK_TIMEOUT > ARM_CYCLES) ? ACK_TIMEOUT : ARM_CYCLES;
    localparam int unsigned TMO_MAX   = (PROC_TIMEOUT > TMO_A) ? PROC_TIMEOUT : TMO_A;
    localparam int unsigned CNT_W     = $clog2(TMO_MAX + 1);

    localparam logic [15:0] CMD_ARM  = 16'hAB30;
    localparam logic [15:0] CMD_GO   = 16'hAB41;
    localparam logic [15:0] CMD_POLL = 16'hAB00;
    localparam logic [15:0] CMD_RD1  = 16'hAB04;
    localparam logic [15:0] CMD_RD2  = 16'hAB08;
    localparam logic [15:0] CMD_RD3  = 16'hAB0C;
    localparam logic [15:0] CMD_REL  = 16'hAB50;

    localparam logic [7:0] TAG_POLL = 8'hC4;
    localparam logic [7:0] TAG_RD1  = 8'hC8;
    localparam logic [7:0] TAG_RD2  = 8'hCC;
    localparam logic [7:0] TAG_RD3  = 8'hD0;

    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_PROC = 2'b10;
    localparam logic [1:0] ERR_COLL = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_WRITE, S_GO, S_POLL, S_RD1, S_RD2, S_RD3, S_RELEASE
    } state_e;

    state_e                          state_q, state_d;
    logic [3:0]                      k_q, k_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_OPS-1:0][OP_W-1:0]    ops_q, ops_d;
    logic [OP_W-1:0]                 wout_q, wout_d;
    logic [OP_W-1:0]                 zout_q, zout_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic [1:0]                      err_code_q, err_code_d;
    logic [127:0]                    la_drv_q, la_drv_d;

    logic [7:0]                      tag;
    logic                            ack_tmo, proc_tmo, arm_done, wr_ack;
    logic                            abort;
    logic [1:0]                      abort_code;
    logic [3:0]                      nxt_k;
    logic [LO_W-1:0]                 nxt_word;
    logic                            nxt_collide;
    logic                            unused_mon;

    // Half-word k (1-based): odd k is the hi half of operand (k-1)/2, even k the lo half.
    function automatic logic [LO_W-1:0] word_of(input logic [NUM_OPS-1:0][OP_W-1:0] ops,
                                                input logic [3:0] k);
        logic [3:0]      idx;
        logic [OP_W-1:0] op;
        idx = (k - 4'd1) >> 1;
        if (idx > 4'(NUM_OPS - 1)) idx = 4'(NUM_OPS - 1);
        op = ops[idx];
        if (k[0]) return {1'b0, op[OP_W-1:LO_W]};
        return op[LO_W-1:0];
    endfunction

    function automatic logic [SEL_W-1:0] therm(input logic [3:0] k);
        logic [SEL_W-1:0] t;
        for (int unsigned i = 0; i < SEL_W; i++) t[i] = (4'(i) < k);
        return t;
    endfunction

    assign tag        = la.la_mon[127:120];
    assign ack_tmo    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign proc_tmo   = (cnt_q == CNT_W'(PROC_TIMEOUT - 1));
    assign arm_done   = (cnt_q == CNT_W'(ARM_CYCLES - 1));
    assign wr_ack     = (k_q == 4'(NUM_WORDS)) ? (la.la_mon[127:122] == 6'b011110)
                                               : (la.la_mon[125:122] == k_q);
    assign unused_mon = ^{la.la_mon[121:114], la.la_mon[31:0]};

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ops_d      = ops_q;
        wout_d     = wout_q;
        zout_d     = zout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        abort      = 1'b0;
        abort_code = 2'b00;

        // The word about to be driven is screened so its cmd overlap can never read as GO.
        nxt_k       = (state_q == S_WRITE && k_q != 4'(NUM_WORDS)) ? k_q + 4'd1 : 4'd1;
        nxt_word    = word_of(ops_q, nxt_k);
        nxt_collide = (nxt_word[31:16] == CMD_GO);

        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    ops_d      = {key, d, inv_w0, z2, w2, z1, w1};
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    busy_d     = 1'b1;
                    k_d        = 4'd0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                if (arm_done) begin
                    if (nxt_collide) begin
                        abort      = 1'b1;
                        abort_code = ERR_COLL;
                    end else begin
                        k_d     = nxt_k;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    if (k_q == 4'(NUM_WORDS)) begin
                        state_d = S_GO;
                    end else if (nxt_collide) begin
                        abort      = 1'b1;
                        abort_code = ERR_COLL;
                    end else begin
                        k_d = nxt_k;
                    end
                end else if (ack_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_ACK;
                end
            end
            S_GO: begin
                if (arm_done) state_d = S_POLL;
            end
            S_POLL: begin
                if (tag == TAG_POLL) begin
                    wout_d[162:82] = la.la_mon[112:32];
                    state_d        = S_RD1;
                end else if (proc_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_PROC;
                end
            end
            S_RD1: begin
                if (tag == TAG_RD1) begin
                    wout_d[81:0] = la.la_mon[113:32];
                    state_d      = S_RD2;
                end else if (ack_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_ACK;
                end
            end
            S_RD2: begin
                if (tag == TAG_RD2) begin
                    zout_d[162:82] = la.la_mon[112:32];
                    state_d        = S_RD3;
                end else if (ack_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_ACK;
                end
            end
            S_RD3: begin
                if (tag == TAG_RD3) begin
                    zout_d[81:0] = la.la_mon[113:32];
                    state_d      = S_RELEASE;
                end else if (ack_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_ACK;
                end
            end
            S_RELEASE: begin
                if (la.la_mon[127:122] == 6'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (ack_tmo) begin
                    abort      = 1'b1;
                    abort_code = ERR_ACK;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            k_d        = 4'd0;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
        end

        // Every state (and every new write word) starts its own timeout window.
        if (state_d != state_q || k_d != k_q || state_q == S_IDLE) cnt_d = '0;
        else                                                        cnt_d = cnt_q + CNT_W'(1);

        la_drv_d = '0;
        case (state_d)
            S_ARM:     la_drv_d[31:16] = CMD_ARM;
            S_WRITE: begin
                la_drv_d[95:82] = therm(k_d);
                la_drv_d[81:0]  = word_of(ops_q, k_d);
            end
            S_GO:      la_drv_d[31:16] = CMD_GO;
            S_POLL:    la_drv_d[31:16] = CMD_POLL;
            S_RD1:     la_drv_d[31:16] = CMD_RD1;
            S_RD2:     la_drv_d[31:16] = CMD_RD2;
            S_RD3:     la_drv_d[31:16] = CMD_RD3;
            S_RELEASE: la_drv_d[31:16] = CMD_REL;
            default:   la_drv_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            ops_q      <= '0;
            wout_q     <= '0;
            zout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            la_drv_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            ops_q      <= ops_d;
            wout_q     <= wout_d;
            zout_q     <= zout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            la_drv_q   <= la_drv_d;
        end
    end

    assign la.la_drv = la_drv_q;
    assign wout      = wout_q;
    assign zout      = zout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_bec_la_host.sv
// Directed bench for bec_la_host against a behavioural LA controller plus core model
// (core result: wout = w1 ^ d, zout = z2 ^ key).
`timescale 1ns/1ps
module tb_bec_la_host;

    localparam int unsigned CW       = 163;
    localparam int unsigned ACK_TMO  = 64;
    localparam int unsigned PROC_TMO = 1000;
    localparam int unsigned ARM_CY   = 2;
    localparam int          CORE_LAT = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [162:0]  w1, z1, w2, z2, inv_w0, d, key;
    logic [162:0]  wout, zout;
    logic          busy, done, err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    bec_la_host_if lai ();

    bec_la_host #(.ACK_TIMEOUT(ACK_TMO), .PROC_TIMEOUT(PROC_TMO), .ARM_CYCLES(ARM_CY)) dut (
        .clk(clk), .rst(rst), .start(start),
        .w1(w1), .z1(z1), .w2(w2), .z2(z2), .inv_w0(inv_w0), .d(d), .key(key),
        .la(lai),
        .wout(wout), .zout(zout), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Behavioural controller + core
    typedef enum logic [1:0] {M_IDLE, M_WR, M_PROC, M_RD} mstate_e;
    mstate_e          m_state;
    logic [13:0][81:0] m_words;
    logic [127:0]     m_mon;
    logic [162:0]     m_wout, m_zout;
    logic             m_hold = 1'b0;
    logic             core_stall = 1'b0;
    logic             ena_seen;
    int               m_pcnt, ack_cnt, ack_bad, last_k, kk;

    wire [15:0] d_cmd = lai.la_drv[31:16];
    wire [13:0] d_sel = lai.la_drv[95:82];
    assign lai.la_mon = m_mon;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE; m_mon <= '0; m_pcnt <= 0; m_words <= '0;
            m_wout <= '0; m_zout <= '0; ena_seen <= 1'b0;
            ack_cnt <= 0; ack_bad <= 0; last_k <= 0;
        end else if (!m_hold) begin
            case (m_state)
                M_IDLE: begin
                    m_mon <= '0;
                    if (d_cmd == 16'hAB30) m_state <= M_WR;
                end
                M_WR: begin
                    if (d_cmd == 16'hAB41) begin
                        m_state <= M_PROC; ena_seen <= 1'b1; m_pcnt <= 0;
                        m_mon <= {8'h9C, 120'b0};
                    end else if (d_sel != 14'd0) begin
                        kk = $countones(d_sel);
                        m_words[kk-1] <= lai.la_drv[81:0];
                        m_mon <= {2'b01, 4'(kk), 122'b0};
                        if (d_sel != 14'((1 << kk) - 1)) ack_bad <= ack_bad + 1;
                        if (kk != last_k) begin
                            ack_cnt <= ack_cnt + 1;
                            if (kk != last_k + 1) ack_bad <= ack_bad + 1;
                            last_k <= kk;
                        end
                    end
                end
                M_PROC: begin
                    m_mon <= {8'h9C, 120'b0};
                    if (!core_stall) begin
                        if (m_pcnt == CORE_LAT - 1) begin
                            m_state <= M_RD;
                            m_wout <= {m_words[0][80:0], m_words[1]} ^ {m_words[10][80:0], m_words[11]};
                            m_zout <= {m_words[6][80:0], m_words[7]} ^ {m_words[12][80:0], m_words[13]};
                        end else m_pcnt <= m_pcnt + 1;
                    end
                end
                M_RD: begin
                    case (d_cmd)
                        16'hAB00: m_mon <= {8'hC4, 7'b0, m_wout[162:82], 32'b0};
                        16'hAB04: m_mon <= {8'hC8, 6'b0, m_wout[81:0], 32'b0};
                        16'hAB08: m_mon <= {8'hCC, 7'b0, m_zout[162:82], 32'b0};
                        16'hAB0C: m_mon <= {8'hD0, 6'b0, m_zout[81:0], 32'b0};
                        16'hAB50: begin m_mon <= '0; m_state <= M_IDLE; end
                        default: ;
                    endcase
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    int done_cnt, max_sel;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= 0; max_sel <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if ($countones(d_sel) > max_sel) max_sel <= $countones(d_sel);
        end
    end

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [162:0] mk_op(input logic [31:0] s);
        return {s[2:0], {5{s}}};
    endfunction

    task automatic set_ops(input logic [31:0] salt);
        w1 = mk_op(32'h1357_9BDF ^ salt); z1 = mk_op(32'h2468_ACE0 ^ salt);
        w2 = mk_op(32'h0F1E_2D3C ^ salt); z2 = mk_op(32'h5A5A_1234 ^ salt);
        inv_w0 = mk_op(32'h7654_3210 ^ salt); d = mk_op(32'hC0DE_F00D ^ salt);
        key = mk_op(32'h0BAD_CAFE ^ salt);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic launch();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output logic timed_out);
        int n = 0;
        timed_out = 1'b1;
        while (n < budget && timed_out) begin
            @(negedge clk); n++;
            if (done || err) timed_out = 1'b0;
        end
    endtask

    task automatic wait_cmd(input logic [15:0] cmd, input int budget, output logic timed_out);
        int n = 0;
        timed_out = 1'b1;
        while (n < budget && timed_out) begin
            @(negedge clk); n++;
            if (d_cmd == cmd && d_sel == 14'd0 && busy) timed_out = 1'b0;
        end
    endtask

    task automatic wait_sel(input int k, input int budget, output logic timed_out);
        int n = 0;
        timed_out = 1'b1;
        while (n < budget && timed_out) begin
            @(negedge clk); n++;
            if ($countones(d_sel) >= k) timed_out = 1'b0;
        end
    endtask

    initial begin
        logic         tmo;
        logic [162:0] exp_w, exp_z;
        int           n;

        // Reset state
        set_ops(32'h0);
        do_reset();
        check("rst_la_drv", CW'(lai.la_drv), '0);
        check("rst_busy",   CW'(busy), '0);
        check("rst_done",   CW'(done), '0);
        check("rst_err",    CW'({err, err_code}), '0);
        check("rst_wout",   wout, '0);

        // 1: full job
        exp_w = w1 ^ d; exp_z = z2 ^ key;
        launch();
        check("t1_busy", CW'(busy), CW'(1));
        wait_end(500, tmo);
        check("t1_tmo",    CW'(tmo), '0);
        check("t1_done",   CW'({done, err}), CW'(2'b10));
        check("t1_wout",   wout, exp_w);
        check("t1_zout",   zout, exp_z);
        check("t1_acks",   CW'(ack_cnt), CW'(14));
        check("t1_ackord", CW'(ack_bad), '0);
        check("t1_ctl_idle", CW'(m_state), CW'(M_IDLE));
        @(negedge clk);
        check("t1_pulse", CW'({done, busy}), '0);
        check("t1_ndone", CW'(done_cnt), CW'(1));

        // 2: collision on w2 hi half
        do_reset();
        w2[113:98] = 16'hAB41;
        launch();
        wait_end(500, tmo);
        check("t2_tmo",     CW'(tmo), '0);
        check("t2_err",     CW'({err, err_code}), CW'(3'b111));
        check("t2_busy",    CW'(busy), '0);
        check("t2_maxsel",  CW'(max_sel), CW'(4));
        check("t2_no_proc", CW'(ena_seen), '0);
        check("t2_la_drv",  CW'(lai.la_drv), '0);
        check("t2_ndone",   CW'(done_cnt), '0);

        // 3: ack timeout with controller held off
        set_ops(32'h0);
        do_reset();
        m_hold = 1'b1;
        launch();
        wait_sel(1, 20, tmo);
        check("t3_word1", CW'(tmo), '0);
        n = 0;
        while (!err && n < 200) begin @(negedge clk); n++; end
        check("t3_cycles", CW'(n), CW'(ACK_TMO));
        check("t3_code",   CW'(err_code), CW'(2'b01));
        m_hold = 1'b0;

        // 4: processing timeout
        do_reset();
        core_stall = 1'b1;
        launch();
        wait_cmd(16'hAB00, 200, tmo);
        check("t4_poll", CW'(tmo), '0);
        n = 1;
        while (!err && n < 1500) begin
            @(negedge clk);
            if (busy && d_cmd == 16'hAB00) n++;
        end
        check("t4_cycles", CW'(n), CW'(PROC_TMO));
        check("t4_code",   CW'({err, err_code}), CW'(3'b110));
        check("t4_busy",   CW'(busy), '0);
        core_stall = 1'b0;

        // 5: reset in RD2, then a clean job
        do_reset();
        launch();
        wait_cmd(16'hAB08, 400, tmo);
        check("t5_rd2", CW'(tmo), '0);
        rst = 1'b1;
        #1;
        check("t5_la_drv", CW'(lai.la_drv), '0);
        check("t5_busy",   CW'(busy), '0);
        check("t5_wout",   wout, '0);
        @(negedge clk); rst = 1'b0;
        launch();
        wait_end(500, tmo);
        check("t5_done", CW'({tmo, done, err}), CW'(3'b010));
        check("t5_wout2", wout, exp_w);
        check("t5_zout2", zout, exp_z);

        // 6: start while busy is ignored
        do_reset();
        launch();
        wait_sel(3, 40, tmo);
        check("t6_write", CW'(tmo), '0);
        set_ops(32'hFFFF_0000);
        launch();
        wait_end(500, tmo);
        check("t6_done", CW'({tmo, done, err}), CW'(3'b010));
        check("t6_wout", wout, exp_w);
        check("t6_zout", zout, exp_z);
        repeat (5) @(negedge clk);
        check("t6_ndone", CW'(done_cnt), CW'(1));
        check("t6_busy",  CW'(busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
